// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit: FSM states, opcodes and
// instruction classes used by the sequencer and the disassembler/monitor.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP       = 4'b0000;
    localparam logic [3:0] OP_ALU_FIRST = 4'b0001;
    localparam logic [3:0] OP_ADD       = 4'b0010;
    localparam logic [3:0] OP_ALU_LAST  = 4'b0011;
    localparam logic [3:0] OP_LD        = 4'b0100;
    localparam logic [3:0] OP_ST        = 4'b0101;
    localparam logic [3:0] OP_JMP       = 4'b0110;
    localparam logic [3:0] OP_JZ        = 4'b0111;
    localparam logic [3:0] OP_HALT      = 4'b1111;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_JMP  = 3'd4,
        CLS_JZ   = 3'd5,
        CLS_HALT = 3'd6
    } instr_class_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the sequencer and the 8-bit CPU datapath.
interface cpu_seq_if;

    logic       run;
    logic [7:0] ir;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;

    logic       imem_req;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       alu_en;
    logic [1:0] alu_op;
    logic       flags_we;
    logic       reg_we;
    logic       wb_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       retire;
    logic [7:0] retired;
    logic       halted;
    logic       fault;
    logic [2:0] state;

    modport master (
        input  run, ir, zero, imem_ready, dmem_ready,
        output imem_req, ir_load, pc_inc, pc_load, alu_en, alu_op, flags_we,
               reg_we, wb_sel, dmem_req, dmem_we, retire, retired, halted,
               fault, state
    );

    modport slave (
        output run, ir, zero, imem_ready, dmem_ready,
        input  imem_req, ir_load, pc_inc, pc_load, alu_en, alu_op, flags_we,
               reg_we, wb_sel, dmem_req, dmem_we, retire, retired, halted,
               fault, state
    );

endinterface

// File: rtl/instr_class_decoder.sv
// Maps an opcode (ir[7:4]) to its instruction class; unknown opcodes are NOPs.
module instr_class_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]   opcode,
    output instr_class_t cls
);

    always_comb begin
        cls = CLS_NOP;
        if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST) begin
            cls = CLS_ALU;
        end else begin
            case (opcode)
                OP_LD:   cls = CLS_LD;
                OP_ST:   cls = CLS_ST;
                OP_JMP:  cls = CLS_JMP;
                OP_JZ:   cls = CLS_JZ;
                OP_HALT: cls = CLS_HALT;
                default: cls = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer; all datapath
// strobes are combinational from the current state and the live inputs.
module cpu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 8
)
(
    input  logic      clk,
    input  logic      reset,
    cpu_seq_if.master bus
);

    localparam int   CNT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int   TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic TO_ON   = (MEM_TIMEOUT > 0);

    state_t            state;
    state_t            next_state;
    state_t            fetch_or_idle;
    instr_class_t      cls;
    logic [CNT_W-1:0]  wait_cnt;
    logic [7:0]        retired;
    logic              waiting;
    logic              timeout;
    logic              unused_ir_low;

    logic       imem_req, ir_load, pc_inc, pc_load, alu_en, flags_we;
    logic       reg_we, wb_sel, dmem_req, dmem_we, retire, halted, fault;
    logic [1:0] alu_op;

    instr_class_decoder u_decoder (
        .opcode (bus.ir[7:4]),
        .cls    (cls)
    );

    assign unused_ir_low = ^bus.ir[3:0];

    assign waiting = (state == ST_FETCH && !bus.imem_ready) ||
                     (state == ST_MEM   && !bus.dmem_ready);
    // Timeout fires in the MEM_TIMEOUT-th cycle of the state; ready is checked first.
    assign timeout       = TO_ON && (wait_cnt == CNT_W'(TO_LAST));
    assign fetch_or_idle = bus.run ? ST_FETCH : ST_IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           wait_cnt <= '0;
        else if (next_state != state)         wait_cnt <= '0;
        else if (waiting && wait_cnt != '1)   wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      retired <= 8'd0;
        else if (retire) retired <= retired + 8'd1;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (bus.run) next_state = ST_FETCH;
            ST_FETCH: begin
                if (bus.imem_ready)   next_state = ST_DECODE;
                else if (timeout)     next_state = ST_FAULT;
            end
            ST_DECODE: begin
                case (cls)
                    CLS_HALT:       next_state = ST_HALT;
                    CLS_ALU:        next_state = ST_EXEC;
                    CLS_LD, CLS_ST: next_state = ST_MEM;
                    default:        next_state = fetch_or_idle;
                endcase
            end
            ST_EXEC:   next_state = ST_WB;
            ST_MEM: begin
                if (bus.dmem_ready)   next_state = (cls == CLS_ST) ? fetch_or_idle : ST_WB;
                else if (timeout)     next_state = ST_FAULT;
            end
            ST_WB:     next_state = fetch_or_idle;
            default:   next_state = state;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        alu_en   = 1'b0;
        flags_we = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        // IR is only trusted once it has been loaded, so alu_op stays 0 before DECODE.
        alu_op   = (state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) ? bus.ir[5:4] : 2'b00;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = bus.imem_ready;
                pc_inc   = bus.imem_ready;
            end
            ST_DECODE: begin
                case (cls)
                    CLS_NOP: retire = 1'b1;
                    CLS_JMP: begin pc_load = 1'b1;     retire = 1'b1; end
                    CLS_JZ:  begin pc_load = bus.zero; retire = 1'b1; end
                    default: retire = 1'b0;
                endcase
            end
            ST_EXEC: begin
                alu_en   = 1'b1;
                flags_we = 1'b1;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == CLS_ST);
                retire   = (cls == CLS_ST) && bus.dmem_ready;
            end
            ST_WB: begin
                reg_we = 1'b1;
                wb_sel = (cls == CLS_LD);
                retire = 1'b1;
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default:  halted = 1'b0;
        endcase
    end

    assign bus.imem_req = imem_req;
    assign bus.ir_load  = ir_load;
    assign bus.pc_inc   = pc_inc;
    assign bus.pc_load  = pc_load;
    assign bus.alu_en   = alu_en;
    assign bus.alu_op   = alu_op;
    assign bus.flags_we = flags_we;
    assign bus.reg_we   = reg_we;
    assign bus.wb_sel   = wb_sel;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.retire   = retire;
    assign bus.retired  = retired;
    assign bus.halted   = halted;
    assign bus.fault    = fault;
    assign bus.state    = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: each instruction is expanded into its
// expected per-cycle trace, which is replayed against the DUT and compared.
module tb_cpu_sequencer;

    localparam int TO = 4;

    localparam logic [12:0] M_IMEM = 13'h1000;
    localparam logic [12:0] M_IRL  = 13'h0800;
    localparam logic [12:0] M_PCI  = 13'h0400;
    localparam logic [12:0] M_PCL  = 13'h0200;
    localparam logic [12:0] M_ALU  = 13'h0100;
    localparam logic [12:0] M_FLG  = 13'h0080;
    localparam logic [12:0] M_REG  = 13'h0040;
    localparam logic [12:0] M_WBS  = 13'h0020;
    localparam logic [12:0] M_DREQ = 13'h0010;
    localparam logic [12:0] M_DWE  = 13'h0008;
    localparam logic [12:0] M_RET  = 13'h0004;
    localparam logic [12:0] M_HLT  = 13'h0002;
    localparam logic [12:0] M_FLT  = 13'h0001;

    typedef struct {
        logic        run;
        logic [7:0]  ir;
        logic        zero;
        logic        ird;
        logic        drd;
        logic [2:0]  st;
        logic [12:0] strb;
        logic [7:0]  ret;
        logic [1:0]  op;
        bit          op_chk;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cpu_seq_if bus();

    cpu_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cyc_t       q[$];
    cyc_t       cur;
    bit         cur_vld = 1'b0;
    logic [7:0] m_ret = 8'd0;
    int         vectors = 0;
    int         miscompares = 0;

    int         cyc = 0, n_reg = 0, n_dwe = 0, n_irl = 0, n_pci = 0, n_pcl = 0;
    int         n_fetch = 0, n_mem = 0, first_fetch = -1, ret4 = -1;
    logic [7:0] wb_hist = 8'd0;

    logic [12:0] strb_act;
    assign strb_act = {bus.imem_req, bus.ir_load, bus.pc_inc, bus.pc_load,
                       bus.alu_en, bus.flags_we, bus.reg_we, bus.wb_sel,
                       bus.dmem_req, bus.dmem_we, bus.retire, bus.halted,
                       bus.fault};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic run, input logic [7:0] ir, input logic z,
                        input logic ird, input logic drd, input logic [2:0] st,
                        input logic [12:0] strb, input bit op_chk);
        cyc_t e;
        e.run = run; e.ir = ir; e.zero = z; e.ird = ird; e.drd = drd;
        e.st = st; e.strb = strb; e.ret = m_ret; e.op = ir[5:4]; e.op_chk = op_chk;
        q.push_back(e);
        if ((strb & M_RET) != 13'h0) m_ret = m_ret + 8'd1;
    endtask

    task automatic idle(input logic run);
        push(run, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 13'h0, 1'b0);
    endtask

    task automatic absorb(input int n, input logic [7:0] ir, input logic [2:0] st, input logic [12:0] strb);
        for (int i = 0; i < n; i++) push(i[0], ir, 1'b0, 1'b1, 1'b1, st, strb, 1'b0);
    endtask

    // Expected trace of one instruction: iw/dw are not-ready cycles before the ready cycle.
    task automatic instr(input logic [7:0] op8, input logic z, input int iw, input int dw, input logic r);
        logic [3:0]  opc;
        logic        is_alu, is_ld, is_st, is_jmp, is_jz, is_halt;
        logic [12:0] dec;
        opc     = op8[7:4];
        is_alu  = (opc >= 4'd1) && (opc <= 4'd3);
        is_ld   = (opc == 4'd4);
        is_st   = (opc == 4'd5);
        is_jmp  = (opc == 4'd6);
        is_jz   = (opc == 4'd7);
        is_halt = (opc == 4'd15);
        for (int i = 0; i < iw && i < TO; i++) push(r, op8, z, 1'b0, 1'b1, 3'd1, M_IMEM, 1'b0);
        if (iw >= TO) return;
        push(r, op8, z, 1'b1, 1'b0, 3'd1, M_IMEM | M_IRL | M_PCI, 1'b0);
        dec = 13'h0;
        if (is_jmp)      dec = M_PCL | M_RET;
        else if (is_jz)  dec = (z ? M_PCL : 13'h0) | M_RET;
        else if (!(is_alu || is_ld || is_st || is_halt)) dec = M_RET;
        push(r, op8, z, 1'b0, 1'b0, 3'd2, dec, 1'b1);
        if (is_alu) begin
            push(r, op8, z, 1'b0, 1'b0, 3'd3, M_ALU | M_FLG, 1'b1);
            push(r, op8, z, 1'b0, 1'b0, 3'd5, M_REG | M_RET, 1'b1);
        end else if (is_ld || is_st) begin
            for (int i = 0; i < dw && i < TO; i++)
                push(r, op8, z, 1'b1, 1'b0, 3'd4, M_DREQ | (is_st ? M_DWE : 13'h0), 1'b1);
            if (dw >= TO) return;
            push(r, op8, z, 1'b0, 1'b1, 3'd4, M_DREQ | (is_st ? (M_DWE | M_RET) : 13'h0), 1'b1);
            if (is_ld) push(r, op8, z, 1'b0, 1'b0, 3'd5, M_REG | M_WBS | M_RET, 1'b1);
        end
    endtask

    task automatic play(input int n);
        for (int k = 0; k < n && q.size() > 0; k++) begin
            @(posedge clk);
            #1;
            cur = q.pop_front();
            bus.run = cur.run; bus.ir = cur.ir; bus.zero = cur.zero;
            bus.imem_ready = cur.ird; bus.dmem_ready = cur.drd;
            cur_vld = 1'b1;
        end
        @(negedge clk);
        #1 cur_vld = 1'b0;
    endtask

    task automatic clr_stats();
        n_reg = 0; n_dwe = 0; n_irl = 0; n_pci = 0; n_pcl = 0;
        n_fetch = 0; n_mem = 0; first_fetch = -1; ret4 = -1; wb_hist = 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        bus.run = 1'b0; bus.ir = 8'h00; bus.zero = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        #1;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_outputs", 32'(strb_act), 32'd0);
        chk("reset_retired", 32'(bus.retired), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_ret = 8'd0;
        q.delete();
        clr_stats();
    endtask

    always @(negedge clk) begin
        if (cur_vld) begin
            cyc++;
            chk("state", 32'(bus.state), 32'(cur.st));
            chk("strobes", 32'(strb_act), 32'(cur.strb));
            chk("retired", 32'(bus.retired), 32'(cur.ret));
            if (cur.op_chk) chk("alu_op", 32'(bus.alu_op), 32'(cur.op));
            if (bus.reg_we) begin n_reg++; wb_hist = {wb_hist[6:0], bus.wb_sel}; end
            if (bus.dmem_we) n_dwe++;
            if (bus.ir_load) n_irl++;
            if (bus.pc_inc)  n_pci++;
            if (bus.pc_load) n_pcl++;
            if (bus.state == 3'd1) begin
                n_fetch++;
                if (first_fetch < 0) first_fetch = cyc;
            end
            if (bus.state == 3'd4) n_mem++;
            if (ret4 < 0 && bus.retired == 8'd4) ret4 = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.run = 1'b1; bus.ir = 8'hF0; bus.zero = 1'b1;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        reset = 1'b0;
        #12;
        chk("init_reset_state", 32'(bus.state), 32'd0);
        chk("init_reset_outputs", 32'(strb_act), 32'd0);
        chk("init_reset_alu_op", 32'(bus.alu_op), 32'd0);
        bus.imem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("start_state", 32'(bus.state), 32'd1);
        chk("start_imem_req", 32'(bus.imem_req), 32'd1);

        // LD, LD, ADD, ST with zero wait states
        do_reset();
        idle(1'b1);
        instr(8'h41, 1'b0, 0, 0, 1'b1);
        instr(8'h42, 1'b0, 0, 0, 1'b1);
        instr(8'h26, 1'b0, 0, 0, 1'b1);
        instr(8'h53, 1'b0, 0, 0, 1'b0);
        idle(1'b0);
        play(1 << 30);
        chk("prog_cycles_to_4", 32'(ret4 - first_fetch), 32'd15);
        chk("prog_reg_we_count", 32'(n_reg), 32'd3);
        chk("prog_wb_sel_seq", 32'(wb_hist[2:0]), 32'b110);
        chk("prog_dmem_we_count", 32'(n_dwe), 32'd1);
        chk("prog_retired", 32'(bus.retired), 32'd4);

        // instruction memory wait states
        do_reset();
        idle(1'b1);
        instr(8'h00, 1'b0, 2, 0, 1'b0);
        idle(1'b0);
        play(1 << 30);
        chk("iwait_fetch_cycles", 32'(n_fetch), 32'd3);
        chk("iwait_ir_load", 32'(n_irl), 32'd1);
        chk("iwait_pc_inc", 32'(n_pci), 32'd1);

        // data memory timeout
        do_reset();
        idle(1'b1);
        instr(8'h41, 1'b0, 0, TO, 1'b1);
        absorb(3, 8'h41, 3'd7, M_FLT);
        play(1 << 30);
        chk("dto_mem_cycles", 32'(n_mem), 32'd4);
        chk("dto_reg_we", 32'(n_reg), 32'd0);
        chk("dto_state", 32'(bus.state), 32'd7);
        chk("dto_fault", 32'(bus.fault), 32'd1);

        // ready in the last allowed cycle is accepted
        do_reset();
        idle(1'b1);
        instr(8'h41, 1'b0, 0, TO - 1, 1'b0);
        idle(1'b0);
        play(1 << 30);
        chk("dlate_mem_cycles", 32'(n_mem), 32'd4);
        chk("dlate_fault", 32'(bus.fault), 32'd0);
        chk("dlate_reg_we", 32'(n_reg), 32'd1);
        chk("dlate_retired", 32'(bus.retired), 32'd1);

        // instruction fetch timeout
        do_reset();
        idle(1'b1);
        instr(8'h00, 1'b0, TO, 0, 1'b1);
        absorb(2, 8'h00, 3'd7, M_FLT);
        play(1 << 30);
        chk("ito_fetch_cycles", 32'(n_fetch), 32'd4);
        chk("ito_ir_load", 32'(n_irl), 32'd0);
        chk("ito_state", 32'(bus.state), 32'd7);

        // jumps, NOP, ALU variants and HALT
        do_reset();
        idle(1'b1);
        instr(8'h70, 1'b1, 0, 0, 1'b1);
        instr(8'h7F, 1'b0, 0, 0, 1'b1);
        instr(8'h65, 1'b0, 0, 0, 1'b1);
        instr(8'h80, 1'b0, 0, 0, 1'b1);
        instr(8'h13, 1'b0, 0, 0, 1'b1);
        instr(8'h38, 1'b0, 0, 0, 1'b1);
        instr(8'hF0, 1'b0, 0, 0, 1'b1);
        absorb(4, 8'hF0, 3'd6, M_HLT);
        play(1 << 30);
        chk("jmp_pc_load_count", 32'(n_pcl), 32'd2);
        chk("halt_retired", 32'(bus.retired), 32'd6);
        chk("halt_flag", 32'(bus.halted), 32'd1);
        chk("halt_state", 32'(bus.state), 32'd6);

        // retired count wraps after 256 instructions
        do_reset();
        idle(1'b1);
        for (int i = 0; i < 255; i++) instr(8'h00, 1'b0, 0, 0, 1'b1);
        instr(8'h0A, 1'b0, 0, 0, 1'b0);
        idle(1'b0);
        play(1 << 30);
        chk("wrap_retired", 32'(bus.retired), 32'd0);

        // asynchronous reset in the middle of MEM
        do_reset();
        idle(1'b1);
        instr(8'h00, 1'b0, 0, 0, 1'b1);
        instr(8'h41, 1'b0, 0, 3, 1'b1);
        play(6);
        chk("amem_state", 32'(bus.state), 32'd4);
        chk("amem_dmem_req", 32'(bus.dmem_req), 32'd1);
        chk("amem_retired", 32'(bus.retired), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_retired", 32'(bus.retired), 32'd0);
        chk("arst_outputs", 32'(strb_act), 32'd0);
        q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
